// File: rtl/lfsr32_hex_source.sv
// lfsr32_hex_source: 32-bit Fibonacci LFSR source feeding the 8-digit hex display
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   run_mode               1 = free-run on prescaler tick, 0 = single-step on key (async, synchronised)
//   step_key               active-low debounced pushbutton (async, synchronised)
//   seed_load, seed_in     rising edge of seed_load loads seed_in into the LFSR
//   freeze                 1 = hold disp_value (async, synchronised)
//   lfsr_q                 current LFSR state
//   disp_value             display snapshot, nibble k drives hex digit k
//   advance                one-cycle pulse aligned with each shift of lfsr_q
//   step_count             shifts since reset or load, wraps
//   lockup_flag            sticky all-zero recovery flag (only with LFSR_LOCKUP_GUARD_EN)
// Optional feature macro: LFSR_LOCKUP_GUARD_EN
module lfsr32_hex_source #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [31:0] SEED_DEFAULT = 32'h00000001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_mode,
  input  logic        step_key,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        freeze,
  output logic [31:0] lfsr_q,
  output logic [31:0] disp_value,
  output logic        advance,
  output logic [15:0] step_count
`ifdef LFSR_LOCKUP_GUARD_EN
  ,
  output logic        lockup_flag
`endif
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);
  logic [SYNC_STAGES-1:0] key_s, key_v, run_s, load_s, frz_s;
  logic key_sync, run_sync, load_sync, frz_sync;
  logic key_prev, run_prev, load_prev;
  logic [CW-1:0] cnt;
  logic tick, key_pulse, load_pulse, req, step, fb;
  logic [31:0] shifted, lfsr_d;
  assign key_sync  = key_s[SYNC_STAGES-1];
  assign run_sync  = run_s[SYNC_STAGES-1];
  assign load_sync = load_s[SYNC_STAGES-1];
  assign frz_sync  = frz_s[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s  <= '1;
      key_v  <= '0;
      run_s  <= '0;
      load_s <= '0;
      frz_s  <= '0;
    end else begin
      key_s  <= {key_s[SYNC_STAGES-2:0], step_key};
      key_v  <= {key_v[SYNC_STAGES-2:0], 1'b1};
      run_s  <= {run_s[SYNC_STAGES-2:0], run_mode};
      load_s <= {load_s[SYNC_STAGES-2:0], seed_load};
      frz_s  <= {frz_s[SYNC_STAGES-2:0], freeze};
    end
  end
  // key_v marks when key_sync holds a real pad sample rather than the reset fill,
  // so a key held low across reset release never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev  <= 1'b0;
      run_prev  <= 1'b0;
      load_prev <= 1'b0;
    end else begin
      key_prev  <= key_v[SYNC_STAGES-1] & key_sync;
      run_prev  <= run_sync;
      load_prev <= load_sync;
    end
  end
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= (run_sync != run_prev || cnt == TOP) ? '0 : cnt + 1'b1;
  end
  always_comb begin
    tick       = cnt == TOP;
    key_pulse  = key_prev & ~key_sync;
    load_pulse = load_sync & ~load_prev;
    req        = run_sync ? tick : key_pulse;
    step       = req & ~load_pulse;
    fb         = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    shifted    = {lfsr_q[30:0], fb};
`ifdef LFSR_LOCKUP_GUARD_EN
    lfsr_d     = load_pulse ? (seed_in == '0 ? SEED_DEFAULT : seed_in) :
                 lfsr_q == '0 ? SEED_DEFAULT : step ? shifted : lfsr_q;
`else
    lfsr_d     = load_pulse ? seed_in : step ? shifted : lfsr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED_DEFAULT;
      disp_value <= SEED_DEFAULT;
      advance    <= 1'b0;
      step_count <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      disp_value <= frz_sync ? disp_value : lfsr_q;
      advance    <= step;
      step_count <= load_pulse ? '0 : step ? step_count + 1'b1 : step_count;
    end
  end
`ifdef LFSR_LOCKUP_GUARD_EN
  always_ff @(posedge clk) begin
    if (reset)
      lockup_flag <= 1'b0;
    else if (load_pulse ? seed_in == '0 : lfsr_q == '0)
      lockup_flag <= 1'b1;
  end
`endif
endmodule
